// File: rtl/sr_frame_pkg.sv
// Shared definitions for the Schumann-resonance field frame receiver:
// sync bytes, parser states and the 3-byte sample decode.
package sr_frame_pkg;

  localparam int unsigned WIDTH   = 18;
  localparam int unsigned N_CH    = 5;
  localparam int unsigned FIELD_W = N_CH * WIDTH;
  localparam int unsigned CH_W    = $clog2(N_CH);

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_HUNT0,
    ST_HUNT1,
    ST_SEQ,
    ST_DATA,
    ST_CHK,
    ST_COMMIT
  } state_t;

  typedef struct packed {
    logic             fmt_err;
    logic [WIDTH-1:0] sample;
  } sample_t;

  // raw = {b0, b1, b2}; b0[7:2] must replicate the sample sign bit b0[1]
  function automatic sample_t decode_sample(input logic [23:0] raw);
    sample_t r;
    r.sample  = raw[WIDTH-1:0];
    r.fmt_err = (raw[23:18] != {6{raw[17]}});
    return r;
  endfunction

endpackage

// File: rtl/sr_frame_field_buffer.sv
// Pending/applied double buffer: commits land in pending, ticks move them to
// the applied field, and a stale field is zeroed after HOLD_TICKS ticks.
module sr_frame_field_buffer
  import sr_frame_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               commit,
  input  logic               tick,
  input  logic [FIELD_W-1:0] field_in,
  output logic [FIELD_W-1:0] field_out,
  output logic               field_valid
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  logic [FIELD_W-1:0] pend_q;
  logic               pend_valid_q;
  logic [HOLD_W-1:0]  hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      hold_q       <= '0;
      field_out    <= '0;
      field_valid  <= 1'b0;
    end else begin
      // apply looks at the registered pending flag, so a same-cycle commit waits a tick
      if (tick) begin
        if (pend_valid_q) begin
          field_out   <= pend_q;
          field_valid <= 1'b1;
          hold_q      <= '0;
        end else if (field_valid) begin
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            field_out   <= '0;
            field_valid <= 1'b0;
            hold_q      <= '0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
      end
      if (commit) begin
        pend_q       <= field_in;
        pend_valid_q <= 1'b1;
      end else if (tick) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sr_field_frame_receiver.sv
// Byte-stream receiver that parses host frames carrying a 5-harmonic field
// and hands good frames to the tick-aligned field buffer.
module sr_field_frame_receiver
  import sr_frame_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 1024,
  parameter int unsigned HOLD_TICKS   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_4khz_en,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [FIELD_W-1:0] sr_field_packed,
  output logic               field_valid,
  output logic               frame_ok,
  output logic               frame_err,
  output logic               seq_gap,
  output logic [15:0]        frame_count,
  output logic [15:0]        err_count
);

  localparam int unsigned IDLE_W = $clog2(BYTE_TIMEOUT);

  state_t                  state_q, state_d;
  logic                    ok_d, err_d, gap_d;
  logic [7:0]              seq_q, xor_q, ref_q;
  logic                    ref_valid_q;
  logic [CH_W-1:0]         ch_idx_q;
  logic [1:0]              pos_q;
  logic [N_CH-1:0][23:0]   shadow_q;
  logic [IDLE_W-1:0]       idle_q;
  logic                    acc_c, framing_c, timeout_c, last_data_c, fmt_err_c;
  logic [FIELD_W-1:0]      field_c;
  sample_t                 dec_c;

  assign acc_c       = s_valid && s_ready;
  assign framing_c   = (state_q == ST_SEQ) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign timeout_c   = framing_c && !acc_c && (idle_q == IDLE_W'(BYTE_TIMEOUT - 1));
  assign last_data_c = (ch_idx_q == CH_W'(N_CH - 1)) && (pos_q == 2'd2);

  // decode all shadow channels; any bad sign extension poisons the frame
  always_comb begin
    fmt_err_c = 1'b0;
    field_c   = '0;
    dec_c     = '0;
    for (int k = 0; k < N_CH; k++) begin
      dec_c     = decode_sample(shadow_q[k]);
      fmt_err_c = fmt_err_c | dec_c.fmt_err;
      field_c[k*WIDTH +: WIDTH] = dec_c.sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HUNT0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    gap_d   = 1'b0;
    case (state_q)
      ST_HUNT0: if (acc_c && s_data == SYNC0) state_d = ST_HUNT1;
      ST_HUNT1: begin
        if (acc_c) begin
          if (s_data == SYNC1)      state_d = ST_SEQ;
          else if (s_data != SYNC0) state_d = ST_HUNT0;
        end
      end
      ST_SEQ:   if (acc_c) state_d = ST_DATA;
      ST_DATA:  if (acc_c && last_data_c) state_d = ST_CHK;
      ST_CHK: begin
        if (acc_c) begin
          if (s_data == xor_q && !fmt_err_c) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_HUNT0;
            err_d   = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_HUNT0;
        ok_d    = 1'b1;
        gap_d   = ref_valid_q && (seq_q != 8'(ref_q + 8'd1));
      end
      default: state_d = ST_HUNT0;
    endcase
    if (timeout_c) begin
      state_d = ST_HUNT0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready     <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      seq_gap     <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
      seq_q       <= '0;
      xor_q       <= '0;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      ch_idx_q    <= '0;
      pos_q       <= '0;
      shadow_q    <= '0;
      idle_q      <= '0;
    end else begin
      s_ready   <= (state_d != ST_COMMIT);
      frame_ok  <= ok_d;
      frame_err <= err_d;
      seq_gap   <= gap_d;
      if (ok_d && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      if (err_d && err_count != 16'hFFFF)  err_count   <= err_count + 16'd1;
      if (ok_d) begin
        ref_q       <= seq_q;
        ref_valid_q <= 1'b1;
      end
      if (acc_c || !framing_c) idle_q <= '0;
      else                     idle_q <= idle_q + IDLE_W'(1);
      if (acc_c && state_q == ST_SEQ) begin
        seq_q    <= s_data;
        xor_q    <= s_data;
        ch_idx_q <= '0;
        pos_q    <= '0;
      end
      if (acc_c && state_q == ST_DATA) begin
        shadow_q[ch_idx_q] <= {shadow_q[ch_idx_q][15:0], s_data};
        xor_q              <= xor_q ^ s_data;
        if (pos_q == 2'd2) begin
          pos_q    <= '0;
          ch_idx_q <= ch_idx_q + CH_W'(1);
        end else begin
          pos_q <= pos_q + 2'd1;
        end
      end
    end
  end

  sr_frame_field_buffer #(
    .HOLD_TICKS (HOLD_TICKS)
  ) u_field_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .commit      (state_q == ST_COMMIT),
    .tick        (clk_4khz_en),
    .field_in    (field_c),
    .field_out   (sr_field_packed),
    .field_valid (field_valid)
  );

endmodule

// File: tb/tb_sr_field_frame_receiver.sv
// Directed bench for sr_field_frame_receiver with a queue-based frame model
// checked against the DUT every cycle plus literal spot checks.
module tb_sr_field_frame_receiver;

  localparam int unsigned W      = 18;
  localparam int unsigned NC     = 5;
  localparam int unsigned FW     = W * NC;
  localparam int unsigned BTO    = 1024;
  localparam int unsigned HOLD   = 64;
  localparam int unsigned FLEN   = 2 + 3 * NC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_4khz_en = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FW-1:0] sr_field_packed;
  logic          field_valid, frame_ok, frame_err, seq_gap;
  logic [15:0]   frame_count, err_count;

  int vectors = 0;
  int miscompares = 0;

  sr_field_frame_receiver #(.BYTE_TIMEOUT(BTO), .HOLD_TICKS(HOLD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk_4khz_en     (clk_4khz_en),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .sr_field_packed (sr_field_packed),
    .field_valid     (field_valid),
    .frame_ok        (frame_ok),
    .frame_err       (frame_err),
    .seq_gap         (seq_gap),
    .frame_count     (frame_count),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_ready, m_ok, m_err, m_gap, m_fv, m_pv;
  logic          m_commit_now, m_in_frame, m_got_a5, m_ref_valid;
  logic [15:0]   m_fcnt, m_ecnt;
  logic [FW-1:0] m_field, m_pend, m_shadow;
  logic [7:0]    m_seq, m_ref;
  logic [7:0]    m_body[$];
  int            m_hold, m_idle;

  task automatic m_reset();
    m_ready = 0; m_ok = 0; m_err = 0; m_gap = 0; m_fv = 0; m_pv = 0;
    m_commit_now = 0; m_in_frame = 0; m_got_a5 = 0; m_ref_valid = 0;
    m_fcnt = 0; m_ecnt = 0; m_field = '0; m_pend = '0; m_shadow = '0;
    m_seq = 0; m_ref = 0; m_hold = 0; m_idle = 0;
    m_body.delete();
  endtask

  task automatic m_judge();
    logic [7:0] x;
    logic [7:0] b0;
    logic       bad;
    x = 8'h00;
    for (int i = 0; i < FLEN - 1; i++) x = x ^ m_body[i];
    bad = (x != m_body[FLEN-1]);
    for (int c = 0; c < NC; c++) begin
      b0 = m_body[1 + 3*c];
      // only 00,01 (positive) and FE,FF (negative) are legal top bytes
      if (!(b0 <= 8'h01 || b0 >= 8'hFE)) bad = 1'b1;
      m_shadow[c*W +: W] = {b0[1:0], m_body[2 + 3*c], m_body[3 + 3*c]};
    end
    if (bad) m_err = 1'b1;
    else begin
      m_commit_now = 1'b1;
      m_seq = m_body[0];
    end
  endtask

  task automatic m_step();
    logic       acc;
    logic [7:0] b;
    acc = s_valid && m_ready;
    b   = s_data;
    m_ok = 0; m_err = 0; m_gap = 0;
    if (clk_4khz_en) begin
      if (m_pv) begin
        m_field = m_pend; m_fv = 1; m_hold = 0; m_pv = 0;
      end else if (m_fv) begin
        m_hold++;
        if (m_hold == HOLD) begin m_field = '0; m_fv = 0; end
      end
    end
    if (m_commit_now) begin
      m_pend = m_shadow; m_pv = 1; m_ok = 1;
      if (m_fcnt != 16'hFFFF) m_fcnt++;
      if (m_ref_valid && int'(m_seq) != (int'(m_ref) + 1) % 256) m_gap = 1;
      m_ref = m_seq; m_ref_valid = 1; m_commit_now = 0;
    end
    if (m_in_frame) begin
      if (acc) begin
        m_idle = 0;
        m_body.push_back(b);
        if (m_body.size() == FLEN) begin
          m_judge();
          m_in_frame = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == BTO) begin m_err = 1; m_in_frame = 0; end
      end
    end else if (acc) begin
      if (m_got_a5 && b == 8'h5A) begin
        m_in_frame = 1; m_body.delete(); m_idle = 0; m_got_a5 = 0;
      end else begin
        m_got_a5 = (b == 8'hA5);
      end
    end
    if (m_err && m_ecnt != 16'hFFFF) m_ecnt++;
    m_ready = !m_commit_now;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("s_ready", 128'(s_ready), 128'(m_ready));
      chk("field", 128'(sr_field_packed), 128'(m_field));
      chk("field_valid", 128'(field_valid), 128'(m_fv));
      chk("frame_ok", 128'(frame_ok), 128'(m_ok));
      chk("frame_err", 128'(frame_err), 128'(m_err));
      chk("seq_gap", 128'(seq_gap), 128'(m_gap));
      chk("frame_count", 128'(frame_count), 128'(m_fcnt));
      chk("err_count", 128'(err_count), 128'(m_ecnt));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] fb[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic tick();
    clk_4khz_en = 1'b1;
    cyc();
    clk_4khz_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) chk("ready_wait", 128'(s_ready), 128'(1));
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic send_fb(input int count);
    for (int i = 0; i < count && i < fb.size(); i++) send_byte(fb[i]);
  endtask

  task automatic fix_chk();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < fb.size() - 1; i++) x = x ^ fb[i];
    fb[fb.size()-1] = x;
  endtask

  task automatic build(input logic [7:0] seq, input logic [W-1:0] s0, input logic [W-1:0] s1,
                       input logic [W-1:0] s2, input logic [W-1:0] s3, input logic [W-1:0] s4);
    logic [W-1:0] s[NC];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3; s[4] = s4;
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'h5A);
    fb.push_back(seq);
    for (int c = 0; c < NC; c++) begin
      fb.push_back({{6{s[c][W-1]}}, s[c][17:16]});
      fb.push_back(s[c][15:8]);
      fb.push_back(s[c][7:0]);
    end
    fb.push_back(8'h00);
    fix_chk();
  endtask

  localparam logic [W-1:0] M1 = 18'h3FFFF;

  initial begin
    cyc();
    cyc();
    chk("reset_ready", 128'(s_ready), 128'(0));
    chk("reset_field", 128'(sr_field_packed), 128'(0));
    rst_n = 1'b1;
    cyc();
    chk("ready_after_release", 128'(s_ready), 128'(1));

    // 1: literal good frame, CHK 0x40
    fb.delete();
    fb = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h40, 8'h00,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40};
    send_fb(FLEN + 2);
    idle(3);
    tick();
    chk("t1_ch0", 128'(sr_field_packed[0 +: W]), 128'(18'h04000));
    chk("t1_ch4", 128'(sr_field_packed[4*W +: W]), 128'(18'h3FFFF));
    chk("t1_valid", 128'(field_valid), 128'(1));
    chk("t1_fcnt", 128'(frame_count), 128'(1));

    // 2: corrupt CHK, then SEQ jump to 0x02
    build(8'h01, 18'd7, 18'd8, 18'd9, 18'd10, 18'd11);
    fb[FLEN+1] = fb[FLEN+1] ^ 8'h01;
    send_fb(FLEN + 2);
    idle(3);
    chk("t2_ecnt", 128'(err_count), 128'(1));
    chk("t2_hold_ch0", 128'(sr_field_packed[0 +: W]), 128'(18'h04000));
    build(8'h02, 18'd1, 18'd2, 18'd3, 18'd4, 18'd5);
    send_fb(FLEN + 2);
    idle(3);
    tick();
    chk("t2_fcnt", 128'(frame_count), 128'(2));

    // 3: format error in ch2, then A5 A5 5A preamble
    build(8'h03, 18'd1, 18'd2, 18'd3, 18'd4, 18'd5);
    fb[3 + 6] = 8'h40;
    fix_chk();
    send_fb(FLEN + 2);
    idle(2);
    chk("t3_ecnt", 128'(err_count), 128'(2));
    send_byte(8'hA5);
    build(8'h03, M1, 18'd100, 18'h20000, 18'h1FFFF, 18'd0);
    send_fb(FLEN + 2);
    idle(2);
    tick();
    chk("t3_ch2", 128'(sr_field_packed[2*W +: W]), 128'(18'h20000));

    // 4: stall after byte 7 until timeout
    build(8'h04, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9);
    send_fb(7);
    idle(BTO + 6);
    chk("t4_ecnt", 128'(err_count), 128'(3));
    send_fb(FLEN + 2);
    idle(2);
    chk("t4_fcnt", 128'(frame_count), 128'(4));

    // 5: overrun (last wins), then commit coincident with tick
    tick();
    build(8'h05, 18'd100, 18'd0, 18'd0, 18'd0, 18'd0);
    send_fb(FLEN + 2);
    build(8'h06, 18'd200, 18'd0, 18'd0, 18'd0, 18'd0);
    send_fb(FLEN + 2);
    idle(2);
    tick();
    chk("t5_ch0_200", 128'(sr_field_packed[0 +: W]), 128'(18'd200));
    build(8'h07, 18'd300, 18'd0, 18'd0, 18'd0, 18'd0);
    send_fb(FLEN + 2);
    tick();
    chk("t5_coinc_old", 128'(sr_field_packed[0 +: W]), 128'(18'd200));
    idle(2);
    tick();
    chk("t5_coinc_new", 128'(sr_field_packed[0 +: W]), 128'(18'd300));

    // 6: hold expiry, then reset mid-DATA
    for (int i = 0; i < HOLD - 1; i++) begin
      idle(2);
      tick();
    end
    chk("t6_valid_63", 128'(field_valid), 128'(1));
    idle(2);
    tick();
    chk("t6_valid_64", 128'(field_valid), 128'(0));
    chk("t6_field_64", 128'(sr_field_packed), 128'(0));
    build(8'h08, 18'd5, 18'd5, 18'd5, 18'd5, 18'd5);
    send_fb(8);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fcnt", 128'(frame_count), 128'(0));
    chk("t6_rst_ready", 128'(s_ready), 128'(0));
    idle(2);
    rst_n = 1'b1;
    idle(1);
    build(8'h10, 18'd77, M1, 18'd1, 18'd2, 18'd3);
    send_fb(FLEN + 2);
    idle(2);
    tick();
    chk("t6_post_ch0", 128'(sr_field_packed[0 +: W]), 128'(18'd77));
    chk("t6_post_fcnt", 128'(frame_count), 128'(1));
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
